seq_display_driver: RTL and testbench
=====================================

Name: seq_display_driver

Overview:
- Downstream consumer of the up/down sequence FSM's 4-bit seq output (codes 0,2,3,5,7,10).
- Converts the sampled code to two decimal digits and drives a 2-digit, time-multiplexed, common-anode 7-segment display.
- Flags codes outside the legal set.
- Pulses the decimal point for a few frames whenever the displayed value changes.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot (min 2); prescaler terminal count is REFRESH_DIV-1.
- FLASH_FRAMES, 8, number of full scan frames the dp stays lit after a value change (1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- seq  input  4  code from sequence FSM
- seg  output 7  segment drive, active-low, seg[0]=a .. seg[6]=g
- an  output 2  digit enables, active-low; an[0]=units, an[1]=tens
- dp  output 1  decimal point, active-low, lit only on units digit
- valid_code  output 1  1 when the currently displayed code is in {0,2,3,5,7,10}

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - an=2'b11, seg=7'h7F, dp=1, valid_code=0
  - prescaler=0, state=BLANK, disp_val=0, prev_val=0, flash_cnt=0
- Input stage: seq is registered into seq_q every clk (1-cycle latency). No other synchronisation is needed because the source is synchronous.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick=1 for one clk when the count equals REFRESH_DIV-1.
- Scan FSM. States: BLANK, DIG0, DIG1. The FSM advances only on tick.
  - BLANK -> DIG0: latch disp_val<=seq_q.
  - DIG0 -> DIG1.
  - DIG1 -> DIG0: latch disp_val<=seq_q. This marks the start of a frame.
  - disp_val is latched only at frame start, so a seq change mid-frame never tears the display.
- Outputs are registered. When tick occurs in cycle T, an/seg/dp reflect the new slot from edge T+1 onward. In BLANK, an=11.
- Decode of disp_val v (4-bit unsigned):
  - v>=10: tens=1, units=v-10. Otherwise tens=0, units=v.
  - Tens digit blanked (seg=7F) when tens=0. Leading-zero suppression applies; the units digit always shows.
  - v=0 shows blank + "0".
  - Illegal code (not in {0,2,3,5,7,10}): tens shows '-', units shows 'E', valid_code=0.
- Segment codes (active-low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - E=06, '-'=3F, blank=7F
- valid_code updates with disp_val, i.e. at frame start, registered.
- Change flash:
  - At each frame-start latch, if the new disp_val differs from prev_val: flash_cnt<=FLASH_FRAMES, then prev_val<=new value.
  - Otherwise, if flash_cnt>0, flash_cnt decrements by 1 at each frame start.
  - dp=0 during DIG0 while flash_cnt>0; dp=1 otherwise.
- The first latch after reset compares against prev_val=0. Code 0 therefore produces no flash; any other code flashes.
- A change coinciding with a flash in progress reloads flash_cnt to FLASH_FRAMES.
- Mid-operation reset returns to BLANK immediately. No partial slot is preserved.

Decomposition:
- Package seq_disp_pkg holds:
  - the state enum (BLANK/DIG0/DIG1)
  - the 7-segment constants
  - the legal-code list
- One combinational sub-module, bin7seg (4-bit digit / E / '-' / blank select -> 7-bit active-low pattern), instantiated once on the muxed digit.
- Prescaler, scan FSM, latch and flash logic stay in the top module.

Test Plan:
Use REFRESH_DIV=4, FLASH_FRAMES=2.
- Reset hold with seq=5:
  - During reset: an=11, seg=7F, dp=1, valid_code=0.
  - After release, an stays 11 for the first 4 clk (BLANK).
- seq=5 steady:
  - Each frame shows an=10 / seg=12, then an=01 / seg=7F.
  - valid_code=1.
  - dp=0 on units for 2 frames, then dp=1.
- seq=10:
  - Units slot an=10 / seg=40; tens slot an=01 / seg=79.
  - valid_code=1.
- seq=4 (illegal):
  - Units seg=06, tens seg=3F, valid_code=0.
- Tear/latch check:
  - Change seq 3->7 in the middle of the DIG0 slot.
  - The DIG1 slot of the same frame still reflects 3.
  - The next frame shows 7 (seg=78) and dp reloads for 2 frames.
- Async reset asserted mid-DIG1:
  - Outputs go to reset values in the same cycle, without waiting for clk.
  - After release, the sequence restarts from BLANK.

Source files
------------

// File: rtl/seq_display_driver_pkg.sv
// Shared types and constants for the sequence-code display driver:
// scan states, segment-symbol selector, active-low patterns, legal codes.
package seq_disp_pkg;

  // Scan slot currently driven onto the display.
  typedef enum logic [1:0] {
    BLANK = 2'd0,
    DIG0  = 2'd1,
    DIG1  = 2'd2
  } scan_state_t;

  // What the shared decoder should draw for the active digit.
  typedef enum logic [1:0] {
    SYM_DIGIT = 2'd0,
    SYM_E     = 2'd1,
    SYM_DASH  = 2'd2,
    SYM_BLANK = 2'd3
  } sym_t;

  // Active-low segment patterns, bit order gfedcba.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Codes the upstream sequence FSM is allowed to produce.
  localparam int          NUM_LEGAL = 6;
  localparam logic [3:0]  LEGAL_CODES [NUM_LEGAL] = '{4'd0, 4'd2, 4'd3, 4'd5, 4'd7, 4'd10};

  function automatic logic is_legal(input logic [3:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LEGAL; i++) begin
      if (code == LEGAL_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/seq_display_driver_bin7seg.sv
// Combinational symbol decoder: decimal digit, 'E', '-' or blank to an
// active-low 7-segment pattern (gfedcba).
module bin7seg
  import seq_disp_pkg::*;
(
  input  sym_t       sym,
  input  logic [3:0] digit,
  output logic [6:0] pattern
);

  // Pick the pattern for the requested symbol.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pattern = SEG_BLANK;
    case (sym)
      SYM_DIGIT: begin
        case (digit)
          4'd0:    pattern = SEG_0;
          4'd1:    pattern = SEG_1;
          4'd2:    pattern = SEG_2;
          4'd3:    pattern = SEG_3;
          4'd4:    pattern = SEG_4;
          4'd5:    pattern = SEG_5;
          4'd6:    pattern = SEG_6;
          4'd7:    pattern = SEG_7;
          4'd8:    pattern = SEG_8;
          4'd9:    pattern = SEG_9;
          default: pattern = SEG_BLANK;
        endcase
      end
      SYM_E:    pattern = SEG_E;
      SYM_DASH: pattern = SEG_DASH;
      default:  pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seq_display_driver.sv
// Two-digit multiplexed common-anode display driver for the sequence FSM
// code. Latches the code once per frame, shows it in decimal, flags
// illegal codes and flashes the units decimal point after a change.
module seq_display_driver
  import seq_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int FLASH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] seq,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp,
  output logic       valid_code
);

  localparam int         PW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

  logic [PW-1:0] presc;
  logic          tick;
  logic          frame_start;
  logic [3:0]    seq_q;
  logic [3:0]    disp_val;
  logic [3:0]    prev_val;
  logic [7:0]    flash_cnt;
  scan_state_t   state;
  scan_state_t   next_state;
  logic [3:0]    shown_val;
  logic [3:0]    units_val;
  logic          has_tens;
  logic [7:0]    next_flash;
  sym_t          sym;
  logic [3:0]    digit;
  logic [6:0]    seg_pat;

  assign tick        = (presc == PRESC_LAST);
  // A frame begins whenever the scan enters the units slot.
  assign frame_start = tick && (state != DIG0);

  // Register the synchronous upstream code once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_q <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      seq_q <= seq;
    end
  end

  // Slot-rate prescaler; tick marks its terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc <= '0;
    else      presc <= tick ? '0 : presc + PW'(1);
  end

  // Next slot, the value it will show, and the symbol to draw there.
  always_comb begin
    next_state = BLANK;
    shown_val  = frame_start ? seq_q : disp_val;
    has_tens   = (shown_val >= 4'd10);
    units_val  = has_tens ? (shown_val - 4'd10) : shown_val;
    next_flash = flash_cnt;
    sym        = SYM_BLANK;
    digit      = 4'd0;

    case (state)
      BLANK:   next_state = DIG0;
      DIG0:    next_state = DIG1;
      DIG1:    next_state = DIG0;
      default: next_state = BLANK;
    endcase

    if (frame_start) begin
      if (seq_q != prev_val)     next_flash = FLASH_LOAD;
      else if (flash_cnt != 8'd0) next_flash = flash_cnt - 8'd1;
    end

    if (!is_legal(shown_val)) begin
      sym = (next_state == DIG0) ? SYM_E : SYM_DASH;
    end else if (next_state == DIG0) begin
      sym   = SYM_DIGIT;
      digit = units_val;
    end else if (has_tens) begin
      sym   = SYM_DIGIT;
      digit = 4'd1;
    end
  end

  bin7seg u_bin7seg (
    .sym     (sym),
    .digit   (digit),
    .pattern (seg_pat)
  );

  // Scan FSM with registered display outputs, frame latch and flash counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BLANK;
      an         <= 2'b11;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      valid_code <= 1'b0;
      disp_val   <= 4'd0;
      prev_val   <= 4'd0;
      flash_cnt  <= 8'd0;
    end else begin
      if (tick) begin
        state <= next_state;
        an    <= (next_state == DIG0) ? 2'b10 : 2'b01;
        seg   <= seg_pat;
        dp    <= !((next_state == DIG0) && (next_flash != 8'd0));
      end
      if (frame_start) begin
        disp_val   <= seq_q;
        flash_cnt  <= next_flash;
        valid_code <= is_legal(seq_q);
        if (seq_q != prev_val) prev_val <= seq_q;
      end
    end
  end

endmodule

// File: tb/tb_seq_display_driver.sv
// Self-checking bench for seq_display_driver (REFRESH_DIV=4, FLASH_FRAMES=2).
// A frame-level reference model tracks edges since reset release and
// predicts every output; tables and directed sequences cover the corners.
module tb_seq_display_driver;

  localparam int DIV   = 4;
  localparam int FLASH = 2;

  logic       clk;
  logic       rst;
  logic [3:0] seq;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;
  logic       valid_code;

  int errors = 0;
  int checks = 0;

  // Reference model state (frame level).
  int e;        // clock edges since reset release
  int seq_q_m;  // code seen by the frame latch
  int disp_m;
  int prev_m;
  int flash_m;
  bit valid_m;

  seq_display_driver #(.REFRESH_DIV(DIV), .FLASH_FRAMES(FLASH)) dut (
    .clk        (clk),
    .rst        (rst),
    .seq        (seq),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .valid_code (valid_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] code;
    logic [6:0] units;
    logic [6:0] tens;
    logic       valid;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(int v);
    return v inside {0, 2, 3, 5, 7, 10};
  endfunction

  function automatic logic [6:0] digit_pat(int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] units_pat(int v);
    return legal(v) ? digit_pat(v % 10) : 7'h06;
  endfunction

  function automatic logic [6:0] tens_pat(int v);
    if (!legal(v)) return 7'h3F;
    return (v / 10 != 0) ? digit_pat(v / 10) : 7'h7F;
  endfunction

  task automatic model_reset();
    e = 0; seq_q_m = 0; disp_m = 0; prev_m = 0; flash_m = 0; valid_m = 1'b0;
  endtask

  // One clock edge in the model; s is the code present at that edge.
  task automatic model_edge(input logic [3:0] s);
    e++;
    if ((e % DIV == 0) && ((e / DIV) % 2 == 1)) begin
      if (seq_q_m != prev_m) begin
        flash_m = FLASH;
        prev_m  = seq_q_m;
      end else if (flash_m > 0) begin
        flash_m--;
      end
      disp_m  = seq_q_m;
      valid_m = legal(seq_q_m);
    end
    seq_q_m = int'(s);
  endtask

  task automatic compare_all();
    logic [1:0] an_x;
    logic [6:0] seg_x;
    logic       dp_x;
    int         slot;
    slot = e / DIV;
    if (!rst || slot == 0) begin
      an_x = 2'b11; seg_x = 7'h7F; dp_x = 1'b1;
    end else if (slot % 2 == 1) begin
      an_x = 2'b10; seg_x = units_pat(disp_m); dp_x = (flash_m > 0) ? 1'b0 : 1'b1;
    end else begin
      an_x = 2'b01; seg_x = tens_pat(disp_m); dp_x = 1'b1;
    end
    check("model_an", 32'(an), 32'(an_x));
    check("model_seg", 32'(seg), 32'(seg_x));
    check("model_dp", 32'(dp), 32'(dp_x));
    check("model_valid", 32'(valid_code), 32'(rst ? valid_m : 1'b0));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge(seq);
    #1;
    compare_all();
  endtask

  // Advance until the display is in the units slot (want_units=1) or tens slot.
  task automatic run_to_slot(input bit want_units);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3 * DIV; i++) begin
      if ((e / DIV) > 0 && (((e / DIV) % 2 == 1) == want_units)) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) check("slot_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    tbl[0] = '{4'd5,  7'h12, 7'h7F, 1'b1};
    tbl[1] = '{4'd10, 7'h40, 7'h79, 1'b1};
    tbl[2] = '{4'd4,  7'h06, 7'h3F, 1'b0};
    tbl[3] = '{4'd0,  7'h40, 7'h7F, 1'b1};
    tbl[4] = '{4'd7,  7'h78, 7'h7F, 1'b1};
    tbl[5] = '{4'd2,  7'h24, 7'h7F, 1'b1};
    tbl[6] = '{4'd3,  7'h30, 7'h7F, 1'b1};
    tbl[7] = '{4'd12, 7'h06, 7'h3F, 1'b0};

    model_reset();
    seq = 4'd5;
    rst = 1'b1;
    #2 rst = 1'b0;

    // Reset hold with seq=5.
    repeat (3) step();
    check("rst_an", 32'(an), 32'h3);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_valid", 32'(valid_code), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < DIV - 1; i++) begin
      step();
      check("blank_an", 32'(an), 32'h3);
    end

    // seq=5 steady: two flashing frames, then dp off.
    for (int f = 1; f <= 3; f++) begin
      run_to_slot(1'b1);
      check("five_units_an", 32'(an), 32'h2);
      check("five_units_seg", 32'(seg), 32'h12);
      check("five_units_dp", 32'(dp), (f <= FLASH) ? 32'h0 : 32'h1);
      check("five_valid", 32'(valid_code), 32'h1);
      run_to_slot(1'b0);
      check("five_tens_an", 32'(an), 32'h1);
      check("five_tens_seg", 32'(seg), 32'h7F);
    end

    // Table of codes: units/tens patterns and legality.
    for (int i = 0; i < 8; i++) begin
      seq = tbl[i].code;
      repeat (4 * DIV) step();
      run_to_slot(1'b1);
      check("tbl_units_seg", 32'(seg), 32'(tbl[i].units));
      check("tbl_units_an", 32'(an), 32'h2);
      check("tbl_valid", 32'(valid_code), 32'(tbl[i].valid));
      run_to_slot(1'b0);
      check("tbl_tens_seg", 32'(seg), 32'(tbl[i].tens));
      check("tbl_tens_an", 32'(an), 32'h1);
    end

    // Tear check: 3 -> 7 mid-DIG0 leaves the current frame untouched.
    seq = 4'd3;
    repeat (6 * DIV) step();
    run_to_slot(1'b1);
    check("tear_pre_seg", 32'(seg), 32'h30);
    check("tear_pre_dp", 32'(dp), 32'h1);
    step();
    seq = 4'd7;
    run_to_slot(1'b0);
    check("tear_dig1_seg", 32'(seg), 32'h7F);
    check("tear_dig1_valid", 32'(valid_code), 32'h1);
    for (int f = 1; f <= 3; f++) begin
      run_to_slot(1'b1);
      check("tear_new_seg", 32'(seg), 32'h78);
      check("tear_new_dp", 32'(dp), (f <= FLASH) ? 32'h0 : 32'h1);
      run_to_slot(1'b0);
    end

    // Async reset in the middle of DIG1, between clock edges.
    step();
    #2 rst = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'h3);
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_dp", 32'(dp), 32'h1);
    check("arst_valid", 32'(valid_code), 32'h0);
    model_reset();
    repeat (2) step();
    rst = 1'b1;
    for (int i = 0; i < DIV - 1; i++) begin
      step();
      check("arst_blank_an", 32'(an), 32'h3);
    end
    step();
    check("arst_restart_an", 32'(an), 32'h2);
    check("arst_restart_seg", 32'(seg), 32'h78);
    check("arst_restart_dp", 32'(dp), 32'h0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          case ($urandom_range(0, 5))
            0: seq = 4'd0;  1: seq = 4'd2;  2: seq = 4'd3;
            3: seq = 4'd5;  4: seq = 4'd7;  default: seq = 4'd10;
          endcase
        end else begin
          seq = 4'($urandom_range(0, 15));
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
